// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the buffered serial transmitter.
// Holds the FSM state encoding, parity mode constants and frame length helper.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int frame_bits(
    input int data_w,
    input int parity_en,
    input int stop_bits
  );
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered full/empty/level.
// Ports: clk, rst (async active-low), we/data_in, re/data_out, full, empty, level.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level_nxt;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  always_comb begin
    level_nxt = level;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_out <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr     <= rptr + AW'(1);
        data_out <= mem[rptr];
      end
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/buffered_serial_tx.sv
// FIFO-buffered async serial transmitter: start, LSB-first data, parity, stop.
// Ports: clk, rst (async active-low), data/we in; full, empty, level, overflow, busy, tx out.
module buffered_serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data,
  input  logic                        we,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_e            state;
  state_e            state_nxt;
  logic              re;
  logic [DATA_W-1:0] rd_data;
  logic [BW-1:0]     baud;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tick;
  logic              timing;
  logic              par_bit;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .re       (re),
    .data_in  (data),
    .data_out (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign tick    = (baud == BAUD_LAST);
  assign timing  = (state != ST_IDLE) && (state != ST_LOAD);
  assign busy    = (state != ST_IDLE);
  // rd_data holds the head word from the LOAD edge until the next LOAD.
  assign par_bit = (^rd_data) ^ PAR_MODE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    re        = 1'b0;
    unique case (state)
      ST_IDLE:   if (!empty) state_nxt = ST_LOAD;
      ST_LOAD: begin
        re        = 1'b1;
        state_nxt = ST_START;
      end
      ST_START:  if (tick) state_nxt = ST_DATA;
      ST_DATA:
        if (tick && bit_cnt == DATA_LAST)
          state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:
        if (tick && bit_cnt == STOP_LAST)
          state_nxt = empty ? ST_IDLE : ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (!timing || tick) baud <= '0;
      else                 baud <= baud + BW'(1);
      if (state_nxt != state) bit_cnt <= '0;
      else if (tick)          bit_cnt <= bit_cnt + CW'(1);
      // The FIFO output register is valid from START, so the
      // shifter takes the word as the start bit ends.
      if (state == ST_START && tick)     shreg <= rd_data;
      else if (state == ST_DATA && tick) shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            overflow <= 1'b0;
    else if (we && full) overflow <= 1'b1;
  end

  always_comb begin
    tx = 1'b1;
    unique case (1'b1)
      (state == ST_START):  tx = 1'b0;
      (state == ST_DATA):   tx = shreg[0];
      (state == ST_PARITY): tx = par_bit;
      default:              tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_buffered_serial_tx.sv
// Scoreboard bench for buffered_serial_tx: three configurations, frame decoders.
// Stimulus pushes expected frames; per-instance monitors decode tx and compare.
module tb_buffered_serial_tx;
  import serial_tx_pkg::*;

  localparam int CPB = 4;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       p;
    int         st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d = '0;
  logic       we0 = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic       full0, full1, full2, empty0, empty1, empty2;
  logic [4:0] level0, level1, level2;
  logic       ovf0, ovf1, ovf2, busy0, busy1, busy2;
  logic       tx0, tx1, tx2;
  logic [2:0] txv;
  int         cyc = 0;
  int         ncmp = 0;
  int         nfail = 0;
  exp_t       exp_q[$];

  assign txv = {tx2, tx1, tx0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  buffered_serial_tx #(.DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data(d), .we(we0), .full(full0), .empty(empty0),
    .level(level0), .overflow(ovf0), .busy(busy0), .tx(tx0));

  buffered_serial_tx #(.DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .data(d), .we(we1), .full(full1), .empty(empty1),
    .level(level1), .overflow(ovf1), .busy(busy1), .tx(tx1));

  buffered_serial_tx #(.DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data(d), .we(we2), .full(full2), .empty(empty2),
    .level(level2), .overflow(ovf2), .busy(busy2), .tx(tx2));

  function automatic int pe_of(input int id);
    return (id == 0) ? 0 : 1;
  endfunction

  function automatic int sb_of(input int id);
    return (id == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic push(input int id, input logic [7:0] v, input logic p,
                      input int st);
    exp_t e;
    e.id = id; e.d = v; e.p = p; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_frame(input int id, input int t0,
                             input logic [15:0] got, input logic stab);
    int         idx;
    int         k;
    logic [15:0] want;
    exp_t       e;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].id == id) begin
        idx = i;
        break;
      end
    if (idx < 0) begin
      chk($sformatf("unexpected_frame_u%0d", id), {16'h0, got}, 32'hffff_ffff);
      return;
    end
    e = exp_q[idx];
    exp_q.delete(idx);
    want = '0;
    for (int b = 0; b < 8; b++) want[1+b] = e.d[b];
    k = 9;
    if (pe_of(id) != 0) begin
      want[k] = e.p;
      k++;
    end
    for (int s = 0; s < sb_of(id); s++) want[k+s] = 1'b1;
    chk($sformatf("frame_bits_u%0d_%02h", id, e.d), {16'h0, got}, {16'h0, want});
    chk($sformatf("bit_stable_u%0d_%02h", id, e.d), {31'h0, stab}, 32'h1);
    if (e.st >= 0)
      chk($sformatf("start_cyc_u%0d_%02h", id, e.d), t0, e.st);
  endtask

  task automatic mon(input int id);
    int          nb;
    int          t0;
    logic [15:0] got;
    logic        stab;
    bit          ab;
    nb = frame_bits(8, pe_of(id), sb_of(id));
    forever begin
      @(negedge clk);
      if (rst && txv[id] == 1'b0) begin
        t0 = cyc; got = '0; stab = 1'b1; ab = 1'b0;
        for (int i = 0; i < nb * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst) begin
            ab = 1'b1;
            break;
          end
          if (i % CPB == 0) got[i/CPB] = txv[id];
          else if (txv[id] != got[i/CPB]) stab = 1'b0;
        end
        if (!ab) check_frame(id, t0, got, stab);
      end
    end
  endtask

  initial fork
    mon(0);
    mon(1);
    mon(2);
  join_none

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, w;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx0}, 32'h1);
    chk("rst_full", {31'h0, full0}, 32'h0);
    chk("rst_empty", {31'h0, empty0}, 32'h1);
    chk("rst_level", {27'h0, level0}, 32'h0);
    chk("rst_ovf", {31'h0, ovf0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single 0xA5 frame
    c = cyc; w = c + 1;
    d = 8'hA5; we0 = 1'b1;
    push(0, 8'hA5, 1'b0, w + 2);
    @(negedge clk); we0 = 1'b0;
    chk("a5_busy_w", {31'h0, busy0}, 32'h0);
    chk("a5_level_w", {27'h0, level0}, 32'h1);
    @(negedge clk);
    chk("a5_busy_load", {31'h0, busy0}, 32'h1);
    chk("a5_tx_load", {31'h0, tx0}, 32'h1);
    @(negedge clk);
    chk("a5_tx_start", {31'h0, tx0}, 32'h0);
    chk("a5_level_read", {27'h0, level0}, 32'h0);
    wait_cyc(w + 41);
    chk("a5_busy_41", {31'h0, busy0}, 32'h1);
    @(negedge clk);
    chk("a5_busy_42", {31'h0, busy0}, 32'h0);
    chk("a5_tx_42", {31'h0, tx0}, 32'h1);
    repeat (3) @(negedge clk);

    // 18 writes into a 16-deep FIFO
    c = cyc; w = c + 1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 17) begin
        chk("ovf_level16", {27'h0, level0}, 32'd16);
        chk("ovf_full16", {31'h0, full0}, 32'h1);
        chk("ovf_not_yet", {31'h0, ovf0}, 32'h0);
      end
      d = 8'h10 + 8'(i); we0 = 1'b1;
      if (i < 17) push(0, 8'h10 + 8'(i), 1'b0, w + 2 + i * 41);
    end
    @(negedge clk); we0 = 1'b0;
    chk("ovf_set", {31'h0, ovf0}, 32'h1);
    chk("ovf_level17", {27'h0, level0}, 32'd16);
    wait_cyc(w + 2 + 17 * 41 + 2);
    chk("ovf_drained_busy", {31'h0, busy0}, 32'h0);
    chk("ovf_drained_empty", {31'h0, empty0}, 32'h1);
    chk("ovf_sticky", {31'h0, ovf0}, 32'h1);

    // write during LOAD with level 5
    @(negedge clk);
    c = cyc; w = c + 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      d = 8'h21 + 8'(i); we0 = 1'b1;
      push(0, 8'h21 + 8'(i), 1'b0, w + 2 + i * 41);
    end
    @(negedge clk); we0 = 1'b0;
    push(0, 8'h27, 1'b0, w + 2 + 6 * 41);
    wait_cyc(w + 42);
    chk("sim_level_load", {27'h0, level0}, 32'd5);
    chk("sim_tx_load", {31'h0, tx0}, 32'h1);
    d = 8'h27; we0 = 1'b1;
    @(negedge clk); we0 = 1'b0;
    chk("sim_level_after", {27'h0, level0}, 32'd5);
    chk("sim_full_after", {31'h0, full0}, 32'h0);
    wait_cyc(w + 2 + 7 * 41 + 2);
    chk("sim_done_busy", {31'h0, busy0}, 32'h0);

    // reset in the middle of a data bit
    c = cyc; w = c + 1;
    d = 8'h5A; we0 = 1'b1;
    @(negedge clk); d = 8'h33;
    @(negedge clk); d = 8'h99;
    @(negedge clk); we0 = 1'b0;
    wait_cyc(w + 12);
    chk("mid_level", {27'h0, level0}, 32'd2);
    chk("mid_busy", {31'h0, busy0}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", {31'h0, tx0}, 32'h1);
    chk("arst_level", {27'h0, level0}, 32'h0);
    chk("arst_empty", {31'h0, empty0}, 32'h1);
    chk("arst_busy", {31'h0, busy0}, 32'h0);
    chk("arst_ovf", {31'h0, ovf0}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    c = cyc;
    d = 8'h3C; we0 = 1'b1;
    push(0, 8'h3C, 1'b0, c + 3);
    @(negedge clk); we0 = 1'b0;
    wait_cyc(c + 1 + 43);
    chk("post_rst_busy", {31'h0, busy0}, 32'h0);

    // odd parity, 2 stop bits, back-to-back
    c = cyc; w = c + 1;
    d = 8'h01; we1 = 1'b1;
    @(negedge clk); d = 8'h80;
    @(negedge clk); d = 8'h00;
    @(negedge clk); we1 = 1'b0;
    push(1, 8'h01, 1'b0, w + 2);
    push(1, 8'h80, 1'b0, w + 51);
    push(1, 8'h00, 1'b1, w + 100);
    wait_cyc(w + 100 + 48 + 2);
    chk("u1_busy_done", {31'h0, busy1}, 32'h0);

    // even parity, 1 stop bit
    c = cyc; w = c + 1;
    d = 8'h07; we2 = 1'b1;
    @(negedge clk); d = 8'h03;
    @(negedge clk); we2 = 1'b0;
    push(2, 8'h07, 1'b1, w + 2);
    push(2, 8'h03, 1'b0, w + 47);
    wait_cyc(w + 47 + 44 + 2);
    chk("u2_busy_done", {31'h0, busy2}, 32'h0);

    repeat (4) @(negedge clk);
    chk("leftover_frames", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
